rob_param: RTL

- Parametrised reorder buffer for the Tomasulo LC-3b core.
- Generalises the fixed 8-entry, single-CDB arrangement to a configurable depth, tag width and number of CDB writeback ports.
- Allocates entries in program order at dispatch, captures results from NUM_CDB broadcast buses, and retires in order to the register file.
- Provides tag-indexed operand lookup for reservation stations, and a full flush for misprediction recovery.

---
 rtl/rob_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocation and retirement, multi-port CDB
// result capture, tag-indexed operand lookup with same-cycle CDB bypass, and full flush.
module rob_param #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int REG_W   = 3,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       alloc_valid,
  input  logic                       alloc_wb,
  input  logic [REG_W-1:0]           alloc_dest,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  input  logic [TAG_W-1:0]           rd_tag_a,
  input  logic [TAG_W-1:0]           rd_tag_b,
  output logic                       rd_ready_a,
  output logic                       rd_ready_b,
  output logic [DATA_W-1:0]          rd_data_a,
  output logic [DATA_W-1:0]          rd_data_b,
  input  logic                       commit_ready,
  output logic                       commit_valid,
  output logic [TAG_W-1:0]           commit_tag,
  output logic                       commit_wb,
  output logic [REG_W-1:0]           commit_dest,
  output logic [DATA_W-1:0]          commit_data,
  output logic                       full,
  output logic                       empty,
  output logic [TAG_W:0]             count
);

  localparam int DEPTH = 2**TAG_W;
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  wb_vec;
  logic [REG_W-1:0]  dest_arr [DEPTH];
  logic [DATA_W-1:0] data_arr [DEPTH];

  logic [TAG_W-1:0]  head_reg, tail_reg;
  logic [TAG_W:0]    count_reg, count_next;
  logic              alloc_fire, commit_fire;

  assign full         = (count_reg == DEPTH_CNT);
  assign empty        = (count_reg == '0);
  assign count        = count_reg;
  assign alloc_ready  = !full;
  assign alloc_tag    = tail_reg;
  // Full is taken from the registered count, so a same-cycle commit never frees a slot early.
  assign alloc_fire   = alloc_valid && !full;

  assign commit_tag   = head_reg;
  assign commit_valid = busy_vec[head_reg] && ready_vec[head_reg];
  assign commit_wb    = wb_vec[head_reg];
  assign commit_dest  = dest_arr[head_reg];
  assign commit_data  = data_arr[head_reg];
  assign commit_fire  = commit_valid && commit_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : entry_g
      logic              busy_reg, ready_reg, wb_reg;
      logic [REG_W-1:0]  dest_reg;
      logic [DATA_W-1:0] data_reg;
      logic              cdb_hit;
      logic [DATA_W-1:0] cdb_wdata;

      // Later ports overwrite earlier ones, so the highest matching port wins.
      always_comb begin
        cdb_hit   = 1'b0;
        cdb_wdata = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
          if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(gi))) begin
            cdb_hit   = 1'b1;
            cdb_wdata = cdb_data[p*DATA_W +: DATA_W];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end else if (commit_fire && (head_reg == TAG_W'(gi))) begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end else if (alloc_fire && (tail_reg == TAG_W'(gi))) begin
          busy_reg  <= 1'b1;
          ready_reg <= 1'b0;
          wb_reg    <= alloc_wb;
          dest_reg  <= alloc_dest;
        end else if (busy_reg && cdb_hit) begin
          ready_reg <= 1'b1;
          data_reg  <= cdb_wdata;
        end
      end

      assign busy_vec[gi]  = busy_reg;
      assign ready_vec[gi] = ready_reg;
      assign wb_vec[gi]    = wb_reg;
      assign dest_arr[gi]  = dest_reg;
      assign data_arr[gi]  = data_reg;
    end
  endgenerate

  logic [TAG_W-1:0]  rd_tag_arr   [2];
  logic              rd_ready_arr [2];
  logic [DATA_W-1:0] rd_data_arr  [2];

  assign rd_tag_arr[0] = rd_tag_a;
  assign rd_tag_arr[1] = rd_tag_b;
  assign rd_ready_a    = rd_ready_arr[0];
  assign rd_ready_b    = rd_ready_arr[1];
  assign rd_data_a     = rd_data_arr[0];
  assign rd_data_b     = rd_data_arr[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : lookup_g
      logic              byp_hit;
      logic [DATA_W-1:0] byp_data;
      logic              sel_busy;

      always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        sel_busy = busy_vec[rd_tag_arr[gi]];
        for (int p = 0; p < NUM_CDB; p++) begin
          if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == rd_tag_arr[gi])) begin
            byp_hit  = 1'b1;
            byp_data = cdb_data[p*DATA_W +: DATA_W];
          end
        end
        rd_ready_arr[gi] = sel_busy && (byp_hit || ready_vec[rd_tag_arr[gi]]);
        if (!sel_busy)
          rd_data_arr[gi] = '0;
        else if (byp_hit)
          rd_data_arr[gi] = byp_data;
        else
          rd_data_arr[gi] = data_arr[rd_tag_arr[gi]];
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({alloc_fire, commit_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_fire)
        tail_reg <= tail_reg + TAG_W'(1);
      if (commit_fire)
        head_reg <= head_reg + TAG_W'(1);
      count_reg <= count_next;
    end
  end

endmodule
